// File: rtl/tcore_rx_deframer.sv
// Receive-side XGMII deframer. Takes 64-bit XGMII with SOF already aligned to lane 0, strips the
// preamble/SFD word and emits frame data as a valid/sop/eop/mod word stream. Each frame is
// length-checked, errors are flagged on eop, and frames the RX FIFO cannot take are dropped.
// Pipeline: s1 input register -> one-word hold -> output register (3 cycles br_* to rx_*).
// Optional feature: define RX_DEFRM_STATS_EN to add good_cnt/err_cnt/drop_cnt counter outputs.
`timescale 1ns/1ps

module tcore_rx_deframer #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        xaui_clk,
  input  logic        reset,
  input  logic        rx_en,
  input  logic        fifo_afull,
  input  logic [63:0] br_data,
  input  logic [7:0]  br_ctrl,
  output logic        rx_val,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic [2:0]  rx_mod,
  output logic        rx_err,
  output logic [63:0] rx_data,
  output logic [13:0] rx_len
`ifdef RX_DEFRM_STATS_EN
  ,
  output logic [31:0] good_cnt,
  output logic [31:0] err_cnt,
  output logic [31:0] drop_cnt
`endif
);

  localparam logic [63:0] SofWord = 64'hD555_5555_5555_55FB;
  localparam logic [7:0]  ChStart = 8'hFB;
  localparam logic [7:0]  ChTerm  = 8'hFD;
  localparam logic [13:0] LenMin  = 14'(MIN_LEN);
  localparam logic [13:0] LenMax  = 14'(MAX_LEN);
  localparam logic [13:0] LenSat  = 14'(MAX_LEN + 1);

  typedef enum logic [1:0] {StIdle, StFrame, StDiscard} state_e;

  // Stage 1 registers
  logic [63:0] s1_data_q;
  logic [7:0]  s1_ctrl_q;
  logic        s1_en_q;
  logic        s1_afull_q;

  // FSM and frame accumulation
  state_e      state_q, state_d;
  logic [13:0] flen_q, flen_d;
  logic        ferr_q, ferr_d;

  // One-word hold
  logic        hold_vld_q, hold_vld_d;
  logic        hold_sop_q, hold_sop_d;
  logic        hold_eop_q, hold_eop_d;
  logic        hold_err_q, hold_err_d;
  logic [2:0]  hold_mod_q, hold_mod_d;
  logic [13:0] hold_len_q, hold_len_d;
  logic [63:0] hold_data_q, hold_data_d;

  // Output registers
  logic        out_val_q, out_val_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;
  logic        out_err_q, out_err_d;
  logic [2:0]  out_mod_q, out_mod_d;
  logic [13:0] out_len_q, out_len_d;
  logic [63:0] out_data_q, out_data_d;

  // Decode of the s1 word
  logic        is_sof;
  logic        sfd_ok;
  logic        sof_accept;
  state_e      sof_state;
  logic [7:0]  term_vec;
  logic        has_term;
  logic [2:0]  term_lane;
  logic [7:0]  below_mask;
  logic        ctrl_below;
  logic [13:0] len_word;
  logic [13:0] len_term;

  // Register the raw XGMII word plus the SOF-time qualifiers
  always_ff @(posedge xaui_clk) begin
    if (reset) begin
      s1_data_q  <= '0;
      s1_ctrl_q  <= '0;
      s1_en_q    <= 1'b0;
      s1_afull_q <= 1'b0;
    end else begin
      s1_data_q  <= br_data;
      s1_ctrl_q  <= br_ctrl;
      s1_en_q    <= rx_en;
      s1_afull_q <= fifo_afull;
    end
  end

  // Decode SOF/terminate and precompute candidate lengths for the s1 word
  always_comb begin
    is_sof     = s1_ctrl_q[0] && (s1_data_q[7:0] == ChStart);
    sfd_ok     = (s1_ctrl_q == 8'h01) && (s1_data_q == SofWord);
    sof_accept = sfd_ok && s1_en_q && !s1_afull_q;
    if (sof_accept) begin
      sof_state = StFrame;
    end else if (sfd_ok) begin
      sof_state = StDiscard;
    end else begin
      sof_state = StIdle;
    end
    term_vec = '0;
    for (int i = 0; i < 8; i++) begin
      term_vec[i] = s1_ctrl_q[i] && (s1_data_q[8*i +: 8] == ChTerm);
    end
    has_term  = |term_vec;
    term_lane = 3'd0;
    // Lowest FD lane wins
    for (int i = 7; i >= 0; i--) begin
      if (term_vec[i]) begin
        term_lane = 3'(i);
      end
    end
    below_mask = (8'h01 << term_lane) - 8'h01;
    ctrl_below = |(s1_ctrl_q & below_mask);
    len_word   = flen_q + 14'd8;
    len_term   = flen_q + {11'd0, term_lane};
  end

  // Next-state: emit the hold every cycle, then let the FSM decide eop and refill the hold
  always_comb begin
    state_d     = state_q;
    flen_d      = flen_q;
    ferr_d      = ferr_q;
    hold_vld_d  = 1'b0;
    hold_sop_d  = hold_sop_q;
    hold_eop_d  = hold_eop_q;
    hold_err_d  = hold_err_q;
    hold_mod_d  = hold_mod_q;
    hold_len_d  = hold_len_q;
    hold_data_d = hold_data_q;

    out_val_d  = hold_vld_q;
    out_data_d = hold_vld_q ? hold_data_q : '0;
    out_sop_d  = hold_vld_q && hold_sop_q;
    out_eop_d  = hold_vld_q && hold_eop_q;
    out_err_d  = hold_vld_q && hold_eop_q && hold_err_q;
    out_mod_d  = (hold_vld_q && hold_eop_q) ? hold_mod_q : 3'd0;
    out_len_d  = (hold_vld_q && hold_eop_q) ? hold_len_q : 14'd0;

    unique case (state_q)
      StIdle: begin
        if (is_sof) begin
          state_d = sof_state;
          flen_d  = '0;
          ferr_d  = 1'b0;
        end
      end
      StFrame: begin
        if (is_sof) begin
          // Frame cut short by a new SOF: close it as errored, then start over
          if (hold_vld_q) begin
            out_eop_d = 1'b1;
            out_err_d = 1'b1;
            out_mod_d = 3'd0;
            out_len_d = flen_q;
          end
          state_d = sof_state;
          flen_d  = '0;
          ferr_d  = 1'b0;
        end else if (has_term) begin
          state_d = StIdle;
          if (term_lane == 3'd0) begin
            if (hold_vld_q) begin
              out_eop_d = 1'b1;
              out_mod_d = 3'd0;
              out_len_d = flen_q;
              out_err_d = ferr_q || (flen_q < LenMin);
            end
          end else begin
            // Partial FD word carries the eop itself
            hold_vld_d  = 1'b1;
            hold_data_d = s1_data_q;
            hold_sop_d  = (flen_q == 14'd0);
            hold_eop_d  = 1'b1;
            hold_mod_d  = term_lane;
            hold_err_d  = ferr_q || ctrl_below || (len_term < LenMin) || (len_term > LenMax);
            hold_len_d  = (len_term > LenMax) ? LenSat : len_term;
          end
        end else begin
          hold_vld_d  = 1'b1;
          hold_data_d = s1_data_q;
          hold_sop_d  = (flen_q == 14'd0);
          hold_mod_d  = 3'd0;
          if (len_word > LenMax) begin
            // Oversize: this word ends the frame, the rest is discarded
            hold_eop_d = 1'b1;
            hold_err_d = 1'b1;
            hold_len_d = LenSat;
            state_d    = StDiscard;
          end else begin
            hold_eop_d = 1'b0;
            hold_err_d = 1'b0;
            hold_len_d = '0;
            flen_d     = len_word;
            ferr_d     = ferr_q || (|s1_ctrl_q);
          end
        end
      end
      StDiscard: begin
        if (is_sof) begin
          state_d = sof_state;
          flen_d  = '0;
          ferr_d  = 1'b0;
        end else if (has_term) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, hold and output registers
  always_ff @(posedge xaui_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      flen_q      <= '0;
      ferr_q      <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_sop_q  <= 1'b0;
      hold_eop_q  <= 1'b0;
      hold_err_q  <= 1'b0;
      hold_mod_q  <= '0;
      hold_len_q  <= '0;
      hold_data_q <= '0;
      out_val_q   <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_mod_q   <= '0;
      out_len_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      flen_q      <= flen_d;
      ferr_q      <= ferr_d;
      hold_vld_q  <= hold_vld_d;
      hold_sop_q  <= hold_sop_d;
      hold_eop_q  <= hold_eop_d;
      hold_err_q  <= hold_err_d;
      hold_mod_q  <= hold_mod_d;
      hold_len_q  <= hold_len_d;
      hold_data_q <= hold_data_d;
      out_val_q   <= out_val_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_err_q   <= out_err_d;
      out_mod_q   <= out_mod_d;
      out_len_q   <= out_len_d;
      out_data_q  <= out_data_d;
    end
  end

  assign rx_val  = out_val_q;
  assign rx_sop  = out_sop_q;
  assign rx_eop  = out_eop_q;
  assign rx_err  = out_err_q;
  assign rx_mod  = out_mod_q;
  assign rx_len  = out_len_q;
  assign rx_data = out_data_q;

`ifdef RX_DEFRM_STATS_EN
  logic        drop_evt;
  logic        zero_evt;
  logic        good_evt;
  logic        bad_evt;
  logic [31:0] good_cnt_q;
  logic [31:0] err_cnt_q;
  logic [31:0] drop_cnt_q;

  // Zero-data frames produce no eop, so they are counted directly
  always_comb begin
    drop_evt = is_sof && !sof_accept;
    zero_evt = (state_q == StFrame) && !hold_vld_q &&
               (is_sof || (has_term && (term_lane == 3'd0)));
    good_evt = out_eop_d && !out_err_d;
    bad_evt  = out_eop_d && out_err_d;
  end

  // Frame statistics counters, free-running with natural wrap
  always_ff @(posedge xaui_clk) begin
    if (reset) begin
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      good_cnt_q <= good_cnt_q + 32'(good_evt);
      err_cnt_q  <= err_cnt_q + 32'(bad_evt) + 32'(zero_evt);
      drop_cnt_q <= drop_cnt_q + 32'(drop_evt);
    end
  end

  assign good_cnt = good_cnt_q;
  assign err_cnt  = err_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule
